otter_fetch_stage: RTL
======================

Name: otter_fetch_stage

Overview:
- Instruction-fetch front end of the pipelined OTTER.
- Owns the program counter and drives the instruction port of the synchronous Memory (1-cycle read latency).
- Produces the IF/DE pipeline register that the decode stage consumes.
- Accepts stall (load-use hazard) and flush/redirect (taken branch/jump resolved in execute) from downstream and inserts bubbles as NOP (0x00000013) with a valid bit.

Parameters:
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset.
- ADDR_WIDTH, 14: width of the word address presented to the memory instruction port.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- STALL  in  1  hold PC and IF/DE register this cycle.
- FLUSH  in  1  redirect fetch to REDIRECT_PC and kill in-flight instruction.
- REDIRECT_PC  in  32  branch/jump target, sampled only when FLUSH=1.
- MEM_RDEN1  out  1  instruction-port read enable.
- MEM_ADDR1  out  ADDR_WIDTH  instruction word address, next_pc[ADDR_WIDTH+1:2].
- MEM_DOUT1  in  32  instruction data; valid the cycle after its address is presented.
- IF_VALID  out  1  IF/DE register holds a real instruction.
- IF_PC  out  32  PC of IF_IR.
- IF_PC_INC  out  32  IF_PC+4.
- IF_IR  out  32  fetched instruction (NOP when invalid).
- FETCH_MISALIGN  out  1  one-cycle pulse: REDIRECT_PC[1:0]!=0 was accepted.
- FETCH_COUNT  out  32  count of valid instructions handed to decode.

Behaviour:
- Interface: one clock (CLK); reset RST is synchronous and active-high.
- Internal regs:
  - pc_q: address whose data is on MEM_DOUT1 this cycle.
  - state: BOOT or RUN.
- next_pc (combinational), priority RST > FLUSH > STALL > advance:
  - RST: RESET_VECTOR.
  - FLUSH: {REDIRECT_PC[31:2],2'b00}.
  - STALL: pc_q.
  - else: pc_q+4, 32-bit wrap (0xFFFF_FFFC -> 0x0000_0000).
- pc_q <= next_pc every cycle. MEM_ADDR1 = next_pc[ADDR_WIDTH+1:2]; address bits above ADDR_WIDTH+1 are ignored.
- MEM_RDEN1 = 1 at all times; during stall the same word is re-read, so MEM_DOUT1 stays stable.
- FSM:
  - BOOT: entered on RST; MEM_DOUT1 not yet meaningful; IF/DE loads a bubble. Next state RUN unconditionally unless RST.
  - RUN: normal fetch. FLUSH does not leave RUN.
- IF/DE update, priority order:
  1. RST: IF_VALID=0, IF_IR=32'h0000_0013, IF_PC=RESET_VECTOR, IF_PC_INC=RESET_VECTOR+4, FETCH_MISALIGN=0, FETCH_COUNT=0.
  2. FLUSH: bubble (IF_VALID=0, IF_IR=NOP); IF_PC/IF_PC_INC hold. The following cycle presents the target's instruction.
  3. STALL: all IF_* outputs hold.
  4. state==BOOT: bubble.
  5. else: IF_IR<=MEM_DOUT1, IF_PC<=pc_q, IF_PC_INC<=pc_q+4, IF_VALID<=1.
- Latency:
  - First valid instruction at IF_* is 2 cycles after RST deasserts (BOOT cycle, then RUN load).
  - Redirect: target appears at IF_* 2 cycles after the FLUSH cycle (1 bubble).
- FLUSH and STALL in the same cycle: FLUSH wins; PC redirected, bubble inserted, stall ignored.
- Stall across many cycles: no limit; outputs and MEM_ADDR1 remain constant.
- FETCH_MISALIGN: registered; 1 for exactly the cycle after a FLUSH with REDIRECT_PC[1:0]!=0; 0 otherwise and on reset.
- FETCH_COUNT: increments by 1 on every cycle where IF_VALID is loaded with 1 (case 5); wraps at 2^32; held under STALL.
- Reset mid-stall or mid-redirect: RST overrides everything in the same cycle.

Test Plan:
- Reset bring-up: memory words 0:0x00000013, 4:0x00100093, 8:0x00208113; RST high 2 cycles, then low -> IF_VALID=0 for 1 cycle after release, then IF_PC=0/IF_IR=0x00000013, then IF_PC=4/IF_IR=0x00100093, IF_PC_INC=8; FETCH_COUNT=2.
- Stall: assert STALL 3 cycles while IF_PC=8 -> IF_PC=8, IF_IR=0x00208113, MEM_ADDR1=3 constant for 3 cycles; after release IF_PC=0xC next cycle; FETCH_COUNT unchanged during stall.
- Redirect: FLUSH=1, REDIRECT_PC=0x40 while IF_PC=0x10 -> next cycle IF_VALID=0, IF_IR=0x00000013; following cycle IF_PC=0x40, IF_PC_INC=0x44, IF_VALID=1.
- FLUSH+STALL same cycle with REDIRECT_PC=0x80 -> identical to plain flush; IF_PC=0x80 two cycles later.
- Misaligned redirect REDIRECT_PC=0x42 -> FETCH_MISALIGN=1 for exactly one cycle; fetch proceeds from 0x40.
- Wrap and reset-override: force pc to 0xFFFFFFFC via FLUSH -> following fetch IF_PC=0x0; asserting RST together with FLUSH -> next cycle IF_PC=RESET_VECTOR, IF_VALID=0, FETCH_COUNT=0.

Source files
------------

// File: rtl/otter_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : otter_fetch_stage
// Description : OTTER instruction-fetch front end. Owns the PC, drives the
//               synchronous memory instruction port, builds the IF/DE register.
// Revision    : 1.0 - initial release
// ============================================================================
module otter_fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          ADDR_WIDTH   = 14
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  STALL,
    input  logic                  FLUSH,
    input  logic [31:0]           REDIRECT_PC,
    output logic                  MEM_RDEN1,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR1,
    input  logic [31:0]           MEM_DOUT1,
    output logic                  IF_VALID,
    output logic [31:0]           IF_PC,
    output logic [31:0]           IF_PC_INC,
    output logic [31:0]           IF_IR,
    output logic                  FETCH_MISALIGN,
    output logic [31:0]           FETCH_COUNT
);

    localparam logic [31:0] c_NOP      = 32'h0000_0013;
    localparam logic [0:0]  c_ST_BOOT  = 1'b0;
    localparam logic [0:0]  c_ST_RUN   = 1'b1;

    logic [31:0] r_pc;
    logic [0:0]  r_state;
    logic [0:0]  w_next_state;
    logic [31:0] w_next_pc;

    logic        r_if_valid;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_pc_inc;
    logic [31:0] r_if_ir;
    logic        r_misalign;
    logic [31:0] r_fetch_count;

    // r_pc is the address whose data is on MEM_DOUT1 this cycle
    always_comb begin
        w_next_pc = r_pc + 32'd4;
        if (RST)
            w_next_pc = RESET_VECTOR;
        else if (FLUSH)
            w_next_pc = {REDIRECT_PC[31:2], 2'b00};
        else if (STALL)
            w_next_pc = r_pc;
    end

    always_comb begin
        w_next_state = c_ST_RUN;
        if (RST)
            w_next_state = c_ST_BOOT;
    end

    always_ff @(posedge CLK) begin
        r_state <= w_next_state;
        r_pc    <= w_next_pc;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_if_valid    <= 1'b0;
            r_if_ir       <= c_NOP;
            r_if_pc       <= RESET_VECTOR;
            r_if_pc_inc   <= RESET_VECTOR + 32'd4;
            r_fetch_count <= 32'd0;
        end else if (FLUSH) begin
            r_if_valid    <= 1'b0;
            r_if_ir       <= c_NOP;
        end else if (STALL) begin
            r_if_valid    <= r_if_valid;
        end else if (r_state == c_ST_BOOT) begin
            r_if_valid    <= 1'b0;
            r_if_ir       <= c_NOP;
        end else begin
            r_if_valid    <= 1'b1;
            r_if_ir       <= MEM_DOUT1;
            r_if_pc       <= r_pc;
            r_if_pc_inc   <= r_pc + 32'd4;
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    // Misalignment is flagged only when a redirect is actually accepted
    always_ff @(posedge CLK) begin
        if (RST)
            r_misalign <= 1'b0;
        else
            r_misalign <= FLUSH && (REDIRECT_PC[1:0] != 2'b00);
    end

    assign MEM_RDEN1      = 1'b1;
    assign MEM_ADDR1      = w_next_pc[ADDR_WIDTH+1:2];
    assign IF_VALID       = r_if_valid;
    assign IF_PC          = r_if_pc;
    assign IF_PC_INC      = r_if_pc_inc;
    assign IF_IR          = r_if_ir;
    assign FETCH_MISALIGN = r_misalign;
    assign FETCH_COUNT    = r_fetch_count;

endmodule
`default_nettype wire
